// File: rtl/ofifo_col_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_col_pkg
//  Description : Shared defaults and helpers for the column output FIFO.
//                Holds the default column count, entry width and depth, the
//                pointer-width function, and the packed-bus slice layout
//                that the SFP stage and the readout controller also use.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofifo_col_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    // Pointer width is log2(depth); depth is a power of two >= 2.
    function automatic int ptr_bw_f(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int PTR_BW_DEF = ptr_bw_f(DEPTH_DEF);

    // Packed-bus layout: column k occupies [(k+1)*w-1 : k*w].
    localparam int BUS_W_DEF = COL_DEF * PSUM_BW_DEF;

    function automatic int col_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofifo_col_if.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_col_if
//  Description : Bus between SFP/readout and the column output FIFO.
//                in/wr  : per-column data and write enables from SFP
//                rd     : row pop strobe from the readout controller
//                o_*    : row data and status back to the readout side
//                master : drives in/wr/rd   slave : the FIFO itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface ofifo_col_if
    import ofifo_col_pkg::*;
#(
    parameter int COL     = COL_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF
);
    logic [COL*PSUM_BW-1:0] in;
    logic [COL-1:0]         wr;
    logic                   rd;
    logic [COL*PSUM_BW-1:0] o_out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output in, wr, rd,
        input  o_out, o_valid, o_full, o_ready, o_overflow, o_underflow
    );

    modport slave (
        input  in, wr, rd,
        output o_out, o_valid, o_full, o_ready, o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/ofifo_col_fifo_col.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_col
//  Description : Single-column synchronous circular-buffer FIFO.
//                clk, reset : clock, async active-high reset
//                wr, din    : write strobe and data (dropped when full)
//                rd         : pop strobe (ignored when empty)
//                dout_head  : entry at the read pointer
//                count      : occupancy 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_col
    import ofifo_col_pkg::*;
#(
    parameter  int WIDTH  = PSUM_BW_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int PTR_BW = ptr_bw_f(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              wr,
    input  wire logic              rd,
    input  wire logic [WIDTH-1:0]  din,
    output      logic [WIDTH-1:0]  dout_head,
    output      logic [PTR_BW:0]   count
);
    localparam logic [PTR_BW:0] c_FULL_CNT = (PTR_BW+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_BW-1:0] wptr_q, wptr_d;
    logic [PTR_BW-1:0] rptr_q, rptr_d;
    logic [PTR_BW:0]   count_q, count_d;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Fullness/emptiness come from the pre-edge count, so a write to a full
    // column is dropped even if a pop happens in the same cycle.
    assign w_wr_acc = wr & (count_q != c_FULL_CNT);
    assign w_rd_acc = rd & (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_wr_acc) begin
            wptr_d = wptr_q + PTR_BW'(1);
        end
        if (w_rd_acc) begin
            rptr_d = rptr_q + PTR_BW'(1);
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + (PTR_BW+1)'(1);
            2'b01:   count_d = count_q - (PTR_BW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout_head = mem_q[rptr_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/ofifo_col.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_col
//  Description : Per-column output FIFO bank between SFP and row writeback.
//                clk, reset : clock, async active-high reset
//                bus.in/wr  : skewed per-column writes from SFP
//                bus.rd     : pop one full row from every column
//                bus.o_out  : registered row, loaded on an accepted rd
//                bus.o_valid/o_full/o_ready : row-level status
//                bus.o_overflow/o_underflow : sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ofifo_col
    import ofifo_col_pkg::*;
#(
    parameter int COL     = COL_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  wire logic  clk,
    input  wire logic  reset,
    ofifo_col_if.slave bus
);
    localparam int              PTR_BW     = ptr_bw_f(DEPTH);
    localparam logic [PTR_BW:0] c_FULL_CNT = (PTR_BW+1)'(DEPTH);

    logic [COL-1:0]            w_col_ne;
    logic [COL-1:0]            w_col_full;
    logic [COL-1:0][PTR_BW:0]  w_count;
    logic [COL*PSUM_BW-1:0]    w_head;
    logic                      w_valid;
    logic                      w_full;
    logic                      w_rd_acc;

    logic [COL*PSUM_BW-1:0]    out_q, out_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;

    // A row pop is only legal when every column holds at least one entry;
    // all columns then pop together so rows stay aligned.
    assign w_rd_acc = bus.rd & w_valid;

    genvar k;
    generate
        for (k = 0; k < COL; k++) begin : g_col
            fifo_col #(
                .WIDTH (PSUM_BW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .wr        (bus.wr[k]),
                .rd        (w_rd_acc),
                .din       (bus.in[col_lsb(k, PSUM_BW) +: PSUM_BW]),
                .dout_head (w_head[col_lsb(k, PSUM_BW) +: PSUM_BW]),
                .count     (w_count[k])
            );
            assign w_col_ne[k]   = (w_count[k] != '0);
            assign w_col_full[k] = (w_count[k] == c_FULL_CNT);
        end
    endgenerate

    assign w_valid = &w_col_ne;
    assign w_full  = |w_col_full;

    always_comb begin
        out_d       = out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_rd_acc) begin
            out_d = w_head;
        end
        if (|(bus.wr & w_col_full)) begin
            overflow_d = 1'b1;
        end
        if (bus.rd & ~w_valid) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.o_out       = out_q;
    assign bus.o_valid     = w_valid;
    assign bus.o_full      = w_full;
    assign bus.o_ready     = ~w_full;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ofifo_col.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofifo_col
//  Description : Directed self-checking bench for ofifo_col.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofifo_col;
    import ofifo_col_pkg::*;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 64;
    localparam int BW      = COL * PSUM_BW;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ofifo_col_if #(.COL(COL), .PSUM_BW(PSUM_BW)) bus ();

    ofifo_col #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] row_of(input logic [15:0] v);
        return {COL{v}};
    endfunction

    // Advance one edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.in = '0;
        bus.wr = '0;
        bus.rd = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++; if (bus.o_out !== '0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", bus.o_out); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.o_overflow); end
        n_checks++; if (bus.o_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf got=%b exp=0", bus.o_underflow); end
    endtask

    task automatic test_skewed_fill();
        logic [BW-1:0] exp_row;
        exp_row = '0;
        for (int k = 0; k < COL; k++) begin
            bus.in = '0;
            bus.in[k*PSUM_BW +: PSUM_BW] = 16'h0100 + 16'(k);
            exp_row[k*PSUM_BW +: PSUM_BW] = 16'h0100 + 16'(k);
            bus.wr = COL'(1) << k;
            step();
            n_checks++;
            if (bus.o_valid !== (k == COL-1)) begin
                n_fail++; $display("FAIL skew_valid col=%0d got=%b exp=%b", k, bus.o_valid, (k == COL-1));
            end
        end
        bus.wr = '0;
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        n_checks++; if (bus.o_out !== exp_row) begin n_fail++; $display("FAIL skew_row got=%h exp=%h", bus.o_out, exp_row); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_valid_after got=%b exp=0", bus.o_valid); end
    endtask

    // Ten rows of lead, then write and read every cycle, then drain.
    // 100 writes carry both pointers past 63.
    task automatic test_order_wrap();
        int rexp;
        rexp = 0;
        for (int i = 0; i < 110; i++) begin
            bus.wr = (i < 100) ? '1 : '0;
            bus.in = row_of(16'(i));
            bus.rd = (i >= 10);
            step();
            if (i >= 10) begin
                n_checks++;
                if (bus.o_out !== row_of(16'(rexp))) begin
                    n_fail++; $display("FAIL wrap_row idx=%0d got=%h exp=%h", rexp, bus.o_out, row_of(16'(rexp)));
                end
                rexp++;
            end
        end
        bus.wr = '0;
        bus.rd = 1'b0;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drained got=%b exp=0", bus.o_valid); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=0", bus.o_overflow); end
    endtask

    task automatic test_full_overflow();
        for (int j = 0; j < DEPTH; j++) begin
            bus.wr = '1;
            bus.in = row_of(16'h2000 + 16'(j));
            step();
            if (j == DEPTH-2) begin
                n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL almost_full got=%b exp=0", bus.o_full); end
            end
        end
        bus.wr = '0;
        n_checks++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL full got=%b exp=1", bus.o_full); end
        n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", bus.o_ready); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL pre_ovf got=%b exp=0", bus.o_overflow); end
        // 65th row is dropped.
        bus.wr = '1;
        bus.in = row_of(16'hBEEF);
        step();
        n_checks++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf got=%b exp=1", bus.o_overflow); end
        // Write to full with a simultaneous pop: the pop happens, the write is still dropped.
        bus.rd = 1'b1;
        step();
        bus.wr = '0;
        n_checks++; if (bus.o_out !== row_of(16'h2000)) begin n_fail++; $display("FAIL full_rdwr got=%h exp=%h", bus.o_out, row_of(16'h2000)); end
        for (int j = 1; j < DEPTH; j++) begin
            step();
            n_checks++;
            if (bus.o_out !== row_of(16'h2000 + 16'(j))) begin
                n_fail++; $display("FAIL full_read idx=%0d got=%h exp=%h", j, bus.o_out, row_of(16'h2000 + 16'(j)));
            end
        end
        bus.rd = 1'b0;
        n_checks++; if (bus.o_out !== row_of(16'h203F)) begin n_fail++; $display("FAIL last_row got=%h exp=%h", bus.o_out, row_of(16'h203F)); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%b exp=0", bus.o_valid); end
        n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL full_clear got=%b exp=0", bus.o_full); end
    endtask

    task automatic test_underflow();
        n_checks++; if (bus.o_underflow !== 1'b0) begin n_fail++; $display("FAIL pre_udf got=%b exp=0", bus.o_underflow); end
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        n_checks++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL udf got=%b exp=1", bus.o_underflow); end
        n_checks++; if (bus.o_out !== row_of(16'h203F)) begin n_fail++; $display("FAIL udf_hold got=%h exp=%h", bus.o_out, row_of(16'h203F)); end
        bus.wr = '1;
        bus.in = row_of(16'h5A5A);
        step();
        bus.wr = '0;
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        n_checks++; if (bus.o_out !== row_of(16'h5A5A)) begin n_fail++; $display("FAIL udf_recover got=%h exp=%h", bus.o_out, row_of(16'h5A5A)); end
        n_checks++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_sticky got=%b exp=1", bus.o_underflow); end
        n_checks++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            bus.wr = '1;
            bus.in = row_of(16'h3000 + 16'(i));
            step();
        end
        bus.wr = '0;
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%b exp=1", bus.o_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.o_out !== '0) begin n_fail++; $display("FAIL ar_out got=%h exp=0", bus.o_out); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", bus.o_valid); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ar_ovf got=%b exp=0", bus.o_overflow); end
        n_checks++; if (bus.o_underflow !== 1'b0) begin n_fail++; $display("FAIL ar_udf got=%b exp=0", bus.o_underflow); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got=%b exp=1", bus.o_ready); end
        #1;
        reset = 1'b0;
        bus.wr = '1;
        bus.in = row_of(16'h4444);
        step();
        bus.wr = '0;
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        n_checks++; if (bus.o_out !== row_of(16'h4444)) begin n_fail++; $display("FAIL ar_first got=%h exp=%h", bus.o_out, row_of(16'h4444)); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_empty got=%b exp=0", bus.o_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_skewed_fill();
        test_order_wrap();
        test_full_overflow();
        test_underflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ofifo_col.md
Name: ofifo_col

Overview:
- Output buffer directly downstream of the SFP accumulate/ReLU stage.
- Holds one independent FIFO per column. Each column is written by its own wr bit, because columns finish skewed.
- Presents complete rows (all columns) to the readout/SRAM writeback controller through a single read strobe.
- Decouples the skewed column completion timing from row-wise memory writeback.

Parameters:
- col, 8, number of columns / independent FIFOs
- psum_bw, 16, width of each column entry
- depth, 64, entries per column FIFO; must be a power of two and ≥2
- ptr_bw, log2(depth), pointer width; derived, not overridden

Ports:
- clk  input  1  clock
- reset  input  1  async active-high reset
- in  input  psum_bw*col  column data from SFP; column k at bits [(k+1)*psum_bw-1 : k*psum_bw]
- wr  input  col  per-column write enable (SFP wr_ofifo)
- rd  input  1  pop one row from all columns
- o_out  output  psum_bw*col  registered row data, same column packing as in
- o_valid  output  1  every column FIFO non-empty (a full row is available)
- o_full  output  1  any column FIFO full
- o_ready  output  1  equals ~o_full
- o_overflow  output  1  sticky; set by any write to a full column
- o_underflow  output  1  sticky; set by rd while o_valid=0

Behaviour:
- Reset (async, active-high):
  - All read/write pointers and occupancy counts return to 0.
  - o_out=0, o_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0.
  - Reset mid-operation discards all stored data immediately.
- Column k storage:
  - Circular buffer of depth entries, each psum_bw bits.
  - wptr and rptr are ptr_bw bits and wrap naturally modulo depth.
  - Occupancy count is ptr_bw+1 bits, range 0..depth.
- Write, per column k:
  - If wr[k]=1 and count_k<depth at the rising edge: store in slice k at wptr_k, then increment wptr_k.
  - If wr[k]=1 and count_k==depth: the write is dropped, storage is unchanged, and o_overflow is set.
  - Fullness is evaluated on the pre-edge count, so a write to a full column is dropped even when rd pops the same cycle.
- Read:
  - If rd=1 and o_valid=1 at the edge: every column pops simultaneously, and o_out is loaded with the head entries of all columns.
  - o_out is valid from the cycle after rd (1-cycle latency) and holds its value until the next accepted rd.
  - If rd=1 and o_valid=0: the read is ignored, o_out is held, no pointers move, and o_underflow is set.
- Simultaneous accepted write and read on a column: count_k is unchanged, and both pointers advance.
- Status flags:
  - o_valid and o_full are combinational from the registered counts.
  - o_valid = AND over k of (count_k≠0).
  - o_full = OR over k of (count_k==depth).
- No data transformation: entries pass bit-exact, with no sign handling.
- Sticky flags clear only on reset.

Decomposition:
- Shared package holds:
  - Defaults for col, psum_bw, depth.
  - A function computing ptr_bw as log2 of depth.
  - Localparams for packed-bus slice offsets, shared with SFP and the readout controller.
- Natural sub-module fifo_col: a single-column synchronous FIFO with depth/width parameters.
  - Ports: clk, reset, wr, rd, din, dout_head, count.
  - ofifo_col instantiates col copies in a generate loop.
  - It adds the row-level o_valid/o_full logic, the o_out register, and the sticky error flags.

Test Plan:
- Reset check: assert reset, then hold wr=0 and rd=0 → o_out=0, o_valid=0, o_full=0, o_ready=1, both sticky flags 0.
- Skewed fill:
  - Stimulus: write column k in cycle k with value 0x0100+k.
  - Required: o_valid stays 0 until the column-7 write lands, then goes 1.
  - Then pulse rd → next cycle o_out row = {0x0107,…,0x0100}, and o_valid=0.
- Ordering and wrap:
  - Stimulus: write 100 rows with row i = i in every column, while reading concurrently so occupancy stays ≤depth.
  - Required: rows come out 0..99 in order; pointers wrap past 63 with no corruption.
- Full and overflow:
  - Stimulus: write 64 rows with no read → o_full=1, o_ready=0.
  - Then write a 65th row of 0xBEEF → o_overflow=1.
  - Then read 64 rows → none equals 0xBEEF, and the last row is the 64th written.
- Underflow: on an empty FIFO, pulse rd → o_underflow=1, o_out unchanged, and a subsequent row write/read still works correctly.
- Async reset mid-stream: with 10 rows buffered, assert reset between clock edges → outputs clear immediately, o_valid=0, and the next written row is the first one read back.
